// File: rtl/pl_rv32_decode_ctrl.sv
// RV32I/M decode-stage controller. It produces a registered control bundle over a
// valid/ready handshake, inserts load-use bubbles and sequences multi-cycle MUL/DIV issue.

package pl_rv32_decode_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SLL    = 4'd1,
    ALU_SLT    = 4'd2,
    ALU_SLTU   = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SRL    = 4'd5,
    ALU_OR     = 4'd6,
    ALU_AND    = 4'd7,
    ALU_SUB    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_opcode_e;

  typedef enum logic { REGISTER_A = 1'b0, PC        = 1'b1 } alu_operand_a_src_e;
  typedef enum logic { REGISTER_B = 1'b0, IMMEDIATE = 1'b1 } alu_operand_b_src_e;

  typedef enum logic [2:0] {
    I_TYPE = 3'd0,
    S_TYPE = 3'd1,
    B_TYPE = 3'd2,
    U_TYPE = 3'd3,
    J_TYPE = 3'd4
  } immediate_select_e;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef struct packed {
    logic               reg_write_en;
    logic               mem_read_en;
    logic               mem_write_en;
    logic               write_back_sel;
    logic               is_branch;
    logic               is_jump;
    logic               is_muldiv;
    logic               illegal;
    alu_opcode_e        alu_op;
    alu_operand_a_src_e alu_src_a_sel;
    alu_operand_b_src_e alu_src_b_sel;
    immediate_select_e  imm_sel;
    logic [2:0]         funct3;
    logic [4:0]         rd;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    reg_write_en:   1'b0,
    mem_read_en:    1'b0,
    mem_write_en:   1'b0,
    write_back_sel: 1'b0,
    is_branch:      1'b0,
    is_jump:        1'b0,
    is_muldiv:      1'b0,
    illegal:        1'b0,
    alu_op:         ALU_ADD,
    alu_src_a_sel:  REGISTER_A,
    alu_src_b_sel:  IMMEDIATE,
    imm_sel:        I_TYPE,
    funct3:         3'd0,
    rd:             5'd0
  };

endpackage

module pl_rv32_decode_ctrl
  import pl_rv32_decode_ctrl_pkg::*;
#(
  parameter int MULDIV_EN        = 0,
  parameter int MULDIV_CYCLES    = 4,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic               flush,
  input  logic               ex_ready,
  output logic               out_valid,
  output logic               reg_write_en,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic               write_back_sel,
  output logic               is_branch,
  output logic               is_jump,
  output logic               is_muldiv,
  output logic               illegal,
  output alu_opcode_e        alu_op,
  output alu_operand_a_src_e alu_src_a_sel,
  output alu_operand_b_src_e alu_src_b_sel,
  output immediate_select_e  imm_sel,
  output logic [2:0]         funct3_out,
  output logic [4:0]         rd_out,
  output logic               busy
);

  typedef enum logic [1:0] { RUN, BUBBLE, MULDIV } state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       out_valid_q, out_valid_d;
  ctrl_t      ctrl_q, ctrl_d, dec;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic       hazard, accept;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // NOTE: every field gets a default before the case, so no path can infer a latch.
  always_comb begin
    dec        = CTRL_RESET;
    dec.funct3 = funct3;
    dec.rd     = rd;
    case (opcode)
      OPC_LOAD: begin
        dec.reg_write_en   = 1'b1;
        dec.mem_read_en    = 1'b1;
        dec.write_back_sel = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.reg_write_en = 1'b1;
        dec.alu_op       = alu_opcode_e'({1'b0, funct3});
        if (funct3 == 3'd5 && funct7 == 7'h20) dec.alu_op = ALU_SRA;
      end
      OPC_AUIPC: begin
        dec.reg_write_en  = 1'b1;
        dec.alu_src_a_sel = PC;
        dec.imm_sel       = U_TYPE;
      end
      OPC_STORE: begin
        dec.mem_write_en = 1'b1;
        dec.imm_sel      = S_TYPE;
      end
      OPC_OP: begin
        dec.alu_src_b_sel = REGISTER_B;
        if (funct7 == 7'h00 || funct7 == 7'h20) begin
          dec.reg_write_en = 1'b1;
          dec.alu_op       = alu_opcode_e'({1'b0, funct3});
          if (funct7 == 7'h20 && funct3 == 3'd0) dec.alu_op = ALU_SUB;
          if (funct7 == 7'h20 && funct3 == 3'd5) dec.alu_op = ALU_SRA;
        end else if (funct7 == 7'h01 && MULDIV_EN != 0) begin
          // The M-ext selector travels on funct3; the ALU just sees ADD.
          dec.reg_write_en = 1'b1;
          dec.is_muldiv    = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.reg_write_en = 1'b1;
        dec.alu_op       = ALU_PASS_B;
        dec.imm_sel      = U_TYPE;
      end
      OPC_BRANCH: begin
        dec.is_branch     = 1'b1;
        dec.alu_src_a_sel = PC;
        dec.alu_src_b_sel = REGISTER_B;
        dec.imm_sel       = B_TYPE;
      end
      OPC_JALR: begin
        dec.reg_write_en = 1'b1;
        dec.is_jump      = 1'b1;
      end
      OPC_JAL: begin
        dec.reg_write_en  = 1'b1;
        dec.is_jump       = 1'b1;
        dec.alu_src_a_sel = PC;
        dec.imm_sel       = J_TYPE;
      end
      OPC_SYSTEM: ;
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal || rd == 5'd0) dec.reg_write_en = 1'b0;
    if (dec.illegal) begin
      dec.mem_read_en  = 1'b0;
      dec.mem_write_en = 1'b0;
    end
  end

  // A held load whose destination feeds the incoming instruction must not be bypassed.
  assign hazard = (LOAD_USE_BUBBLES > 0) && in_valid && out_valid_q &&
                  ctrl_q.mem_read_en && (ctrl_q.rd != 5'd0) &&
                  (rs1 == ctrl_q.rd || rs2 == ctrl_q.rd);

  assign in_ready = (!out_valid_q || ex_ready) && (state_q == RUN) && !hazard;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;

    unique case (state_q)
      RUN: begin
        if (hazard && ex_ready) begin
          state_d = BUBBLE;
          cnt_d   = 5'(LOAD_USE_BUBBLES);
        end else if (accept && dec.is_muldiv) begin
          state_d = MULDIV;
          cnt_d   = 5'(MULDIV_CYCLES - 1);
        end
      end
      BUBBLE: begin
        if (cnt_q <= 5'd1) begin
          state_d = RUN;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      MULDIV: begin
        if (cnt_q == 5'd0) begin
          if (ex_ready) state_d = RUN;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 5'd0;
      end
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      ctrl_d      = dec;
    end else if (ex_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      state_d     = RUN;
      cnt_d       = 5'd0;
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 5'd0;
      out_valid_q <= 1'b0;
      ctrl_q      <= CTRL_RESET;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign reg_write_en   = ctrl_q.reg_write_en;
  assign mem_read_en    = ctrl_q.mem_read_en;
  assign mem_write_en   = ctrl_q.mem_write_en;
  assign write_back_sel = ctrl_q.write_back_sel;
  assign is_branch      = ctrl_q.is_branch;
  assign is_jump        = ctrl_q.is_jump;
  assign is_muldiv      = ctrl_q.is_muldiv;
  assign illegal        = ctrl_q.illegal;
  assign alu_op         = ctrl_q.alu_op;
  assign alu_src_a_sel  = ctrl_q.alu_src_a_sel;
  assign alu_src_b_sel  = ctrl_q.alu_src_b_sel;
  assign imm_sel        = ctrl_q.imm_sel;
  assign funct3_out     = ctrl_q.funct3;
  assign rd_out         = ctrl_q.rd;
  assign busy           = (state_q != RUN);

endmodule

// File: tb/tb_pl_rv32_decode_ctrl.sv
// Bench for pl_rv32_decode_ctrl: directed handshake/hazard/MULDIV/flush/reset checks
// plus a scoreboard comparing every handed-off bundle against an independent decode model.

module tb_pl_rv32_decode_ctrl;
  import pl_rv32_decode_ctrl_pkg::*;

  localparam int MD_EN  = 1;
  localparam int MD_CYC = 4;
  localparam int LUB    = 1;

  logic               clk = 1'b0;
  logic               rst, in_valid, in_ready, flush, ex_ready, out_valid;
  logic [31:0]        instr;
  logic               reg_write_en, mem_read_en, mem_write_en, write_back_sel;
  logic               is_branch, is_jump, is_muldiv, illegal, busy;
  alu_opcode_e        alu_op;
  alu_operand_a_src_e alu_src_a_sel;
  alu_operand_b_src_e alu_src_b_sel;
  immediate_select_e  imm_sel;
  logic [2:0]         funct3_out;
  logic [4:0]         rd_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  pl_rv32_decode_ctrl #(
    .MULDIV_EN(MD_EN), .MULDIV_CYCLES(MD_CYC), .LOAD_USE_BUBBLES(LUB)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .ex_ready(ex_ready), .out_valid(out_valid),
    .reg_write_en(reg_write_en), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .write_back_sel(write_back_sel), .is_branch(is_branch), .is_jump(is_jump),
    .is_muldiv(is_muldiv), .illegal(illegal), .alu_op(alu_op),
    .alu_src_a_sel(alu_src_a_sel), .alu_src_b_sel(alu_src_b_sel), .imm_sel(imm_sel),
    .funct3_out(funct3_out), .rd_out(rd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Bundle layout: {8 flags, alu_op[3:0], src_a, src_b, imm_sel[2:0], funct3, rd}.
  function automatic logic [31:0] dut_bundle();
    return 32'({reg_write_en, mem_read_en, mem_write_en, write_back_sel, is_branch,
                is_jump, is_muldiv, illegal, alu_op, alu_src_a_sel, alu_src_b_sel,
                imm_sel, funct3_out, rd_out});
  endfunction

  function automatic logic [31:0] reset_bundle();
    return 32'({8'b0, 4'(ALU_ADD), 1'(REGISTER_A), 1'(IMMEDIATE), 3'(I_TYPE), 3'b0, 5'b0});
  endfunction

  function automatic logic [31:0] ref_bundle(input logic [31:0] w);
    logic [6:0] op, f7;
    logic [2:0] f3, imm;
    logic [4:0] rd;
    logic [3:0] alu;
    logic known, md, ill, wr, mr, mw, wb, br, jmp, a, b;
    op = w[6:0];  rd = w[11:7];  f3 = w[14:12];  f7 = w[31:25];
    known = op inside {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    md  = (op == 7'h33) && (f7 == 7'h01) && (MD_EN != 0);
    ill = !known || ((op == 7'h33) && !(f7 == 7'h00 || f7 == 7'h20 || md));
    wr  = (op inside {7'h03, 7'h13, 7'h17, 7'h33, 7'h37, 7'h67, 7'h6F}) && !ill && (rd != 5'd0);
    mr  = (op == 7'h03);
    mw  = (op == 7'h23);
    wb  = (op == 7'h03);
    br  = (op == 7'h63);
    jmp = (op == 7'h67) || (op == 7'h6F);
    a   = (op == 7'h17) || (op == 7'h6F) || (op == 7'h63);
    b   = !((op == 7'h33) || (op == 7'h63));
    if (op == 7'h23)                      imm = 3'(S_TYPE);
    else if (op == 7'h63)                 imm = 3'(B_TYPE);
    else if (op == 7'h6F)                 imm = 3'(J_TYPE);
    else if (op == 7'h37 || op == 7'h17)  imm = 3'(U_TYPE);
    else                                  imm = 3'(I_TYPE);
    alu = 4'(ALU_ADD);
    if (op == 7'h37) alu = 4'(ALU_PASS_B);
    else if ((op == 7'h13) || (op == 7'h33 && (f7 == 7'h00 || f7 == 7'h20))) begin
      case (f3)
        3'd0:    alu = (op == 7'h33 && f7 == 7'h20) ? 4'(ALU_SUB) : 4'(ALU_ADD);
        3'd5:    alu = (f7 == 7'h20) ? 4'(ALU_SRA) : 4'(ALU_SRL);
        default: alu = {1'b0, f3};
      endcase
    end
    return 32'({wr, mr, mw, wb, br, jmp, md, ill, alu, a, b, imm, f3, rd});
  endfunction

  // Scoreboard: expected bundles pushed on acceptance, popped on hand-off or flush discard.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && (ex_ready || flush)) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          if (ex_ready) check("sb_bundle", dut_bundle(), e);
        end
      end
      if (in_valid && in_ready && !flush) exp_q.push_back(ref_bundle(instr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    bit acc;
    in_valid = 1'b1;
    instr    = w;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 40) begin
      #3;
      acc = in_ready && !flush;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'(0));
  endtask

  localparam logic [31:0] ADDI_X1  = 32'h00500093;
  localparam logic [31:0] LW_X2    = 32'h0000A103;
  localparam logic [31:0] ADD_X3   = 32'h002101B3;
  localparam logic [31:0] MUL_X4   = 32'h02208233;
  localparam logic [31:0] ADD_X0   = 32'h00208033;
  localparam logic [31:0] OPC_7F   = 32'h0000017F;
  localparam logic [31:0] BAD_F7   = 32'h802081B3;
  localparam logic [31:0] ORI_X8   = 32'h00F0E413;

  logic [31:0] patterns[12] = '{
    32'h402082B3,  // SUB x5,x1,x2
    32'h4020D333,  // SRA x6,x1,x2
    32'h4030D393,  // SRAI x7,x1,3
    32'h40008093,  // ADDI with bit30 set stays ADD
    32'h123454B7,  // LUI
    32'h00001517,  // AUIPC
    32'h0020A223,  // SW
    32'h00208463,  // BEQ
    32'h010000EF,  // JAL x1
    32'h00008067,  // JALR x0
    32'h00000073,  // ECALL
    32'h0020B5B3   // SLTU x11
  };

  initial begin
    int rdy_hi, n;
    rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0; ex_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_bundle", dut_bundle(), reset_bundle());
    rst = 1'b0;
    #1 check("post_rst_ready", 32'(in_ready), 32'(1));
    tick();

    // ADDI x1,x0,5
    send(ADDI_X1);
    check("addi_valid", 32'(out_valid), 32'(1));
    check("addi_alu", 32'(alu_op), 32'(ALU_ADD));
    check("addi_imm", 32'(imm_sel), 32'(I_TYPE));
    check("addi_we", 32'(reg_write_en), 32'(1));
    check("addi_rd", 32'(rd_out), 32'(1));

    // Load-use: LW x2 then ADD x3,x2,x2
    tick();
    send(LW_X2);
    in_valid = 1'b1; instr = ADD_X3;
    #1 check("lu_hazard_ready", 32'(in_ready), 32'(0));
    tick();
    check("lu_bubble_valid", 32'(out_valid), 32'(0));
    check("lu_bubble_ready", 32'(in_ready), 32'(0));
    check("lu_bubble_busy", 32'(busy), 32'(1));
    tick();
    check("lu_resume_ready", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    check("lu_add_valid", 32'(out_valid), 32'(1));
    check("lu_add_rd", 32'(rd_out), 32'(3));

    // MUL x4,x1,x2: 4 busy cycles with in_ready low
    tick();
    send(MUL_X4);
    check("md_flag", 32'(is_muldiv), 32'(1));
    check("md_alu", 32'(alu_op), 32'(ALU_ADD));
    n = 0; rdy_hi = 0;
    while (busy && n < 40) begin
      if (in_ready) rdy_hi++;
      n++;
      tick();
    end
    check("md_busy_cycles", 32'(n), 32'(MD_CYC));
    check("md_ready_low", 32'(rdy_hi), 32'(0));

    // Hazard and MUL together: bubble first, MULDIV on later acceptance
    send(LW_X2);
    in_valid = 1'b1; instr = MUL_X4;
    #1 check("hzmd_ready", 32'(in_ready), 32'(0));
    tick();
    check("hzmd_bubble", 32'(busy && !out_valid), 32'(1));
    tick(); tick();
    in_valid = 1'b0;
    check("hzmd_muldiv", 32'(is_muldiv && busy && out_valid), 32'(1));
    wait_idle();

    // rd=0 and illegal forms
    send(ADD_X0);
    check("rd0_we", 32'(reg_write_en), 32'(0));
    send(OPC_7F);
    check("ill7f_flag", 32'(illegal), 32'(1));
    check("ill7f_we", 32'({reg_write_en, mem_read_en, mem_write_en}), 32'(0));
    send(BAD_F7);
    check("illf7_flag", 32'(illegal), 32'(1));
    check("illf7_we", 32'(reg_write_en), 32'(0));

    // Pattern sweep through the scoreboard
    foreach (patterns[i]) send(patterns[i]);
    tick();

    // Flush during MULDIV countdown
    send(MUL_X4);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_md_valid", 32'(out_valid), 32'(0));
    check("flush_md_busy", 32'(busy), 32'(0));
    check("flush_md_ready", 32'(in_ready), 32'(1));

    // Instruction presented alongside flush is dropped
    in_valid = 1'b1; instr = ADDI_X1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_noaccept", 32'(out_valid), 32'(0));

    // ex_ready stall holds the bundle
    ex_ready = 1'b0;
    send(ORI_X8);
    in_valid = 1'b1; instr = ADDI_X1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid", 32'(out_valid), 32'(1));
      check("stall_bundle", dut_bundle(), ref_bundle(ORI_X8));
      check("stall_ready", 32'(in_ready), 32'(0));
      tick();
    end
    ex_ready = 1'b1;
    #1 check("stall_release", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    tick();

    // Reset pulse mid-MULDIV
    send(MUL_X4);
    tick();
    rst = 1'b1;
    tick();
    check("rstp_valid", 32'(out_valid), 32'(0));
    check("rstp_busy", 32'(busy), 32'(0));
    check("rstp_bundle", dut_bundle(), reset_bundle());
    rst = 1'b0;
    #1 check("rstp_ready", 32'(in_ready), 32'(1));

    tick(); tick();
    check("sb_drain", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
